// File: rtl/axi_master_if.sv
// axi_master_if: AXI4 address/data/response channel bundle between a burst master and a slave.
interface axi_master_if;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [1:0]  bresp, rresp;
  modport master(
    output awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
  modport slave(
    input  awvalid, awaddr, wvalid, wdata, wlast, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_master.sv
// axi_master: single-outstanding fixed-length INCR burst master; define AXI_MASTER_TIMEOUT_EN for a per-state watchdog.
module axi_master #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic        usr_wvalid,
  output logic        usr_wready,
  input  logic [31:0] usr_wdata,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  axi_master_if.master m
);
  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] awaddr_q, awaddr_d, araddr_q, araddr_d, rd_data_q, rd_data_d;
  logic        awvalid_q, awvalid_d, arvalid_q, arvalid_d, rd_valid_q, rd_valid_d;
  logic        done_q, done_d, err_q, err_d, cmd_ready_q, cmd_ready_d;
  logic        last, wbeat, tmo_hit;
  assign last  = cnt_q == 8'(BURST_LEN - 1);
  assign wbeat = state_q == WDATA && usr_wvalid && m.wready;
`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  assign tmo_hit = state_q != IDLE && tmo_q == TW'(TIMEOUT - 1);
  assign tmo_d   = (state_d != state_q || state_q == IDLE) ? '0 : tmo_q + TW'(1);
  always_ff @(posedge aclk or negedge areset)
    if (!areset) tmo_q <= '0;
    else tmo_q <= tmo_d;
`else
  assign tmo_hit = 1'b0 && TIMEOUT != 0;
`endif
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    rd_data_d  = rd_data_q;
    awvalid_d  = awvalid_q;
    arvalid_d  = arvalid_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    if (state_q == IDLE && cmd_valid && cmd_ready_q) begin
      state_d   = cmd_write ? WADDR : RADDR;
      cnt_d     = '0;
      err_d     = 1'b0;
      awaddr_d  = cmd_write ? cmd_addr : awaddr_q;
      araddr_d  = cmd_write ? araddr_q : cmd_addr;
      awvalid_d = cmd_write;
      arvalid_d = !cmd_write;
    end
    if (state_q == WADDR && m.awready) begin
      awvalid_d = 1'b0;
      state_d   = WDATA;
    end
    if (state_q == RADDR && m.arready) begin
      arvalid_d = 1'b0;
      state_d   = RDATA;
    end
    if (wbeat) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = last ? WRESP : state_q;
    end
    if (state_q == WRESP && m.bvalid) begin
      err_d   = m.bresp > 2'd1;
      done_d  = 1'b1;
      state_d = IDLE;
    end
    // A missing or misplaced rlast is an error, but the burst length is ours, not the slave's
    if (state_q == RDATA && m.rvalid) begin
      rd_data_d  = m.rdata;
      rd_valid_d = 1'b1;
      cnt_d      = cnt_q + 8'd1;
      err_d      = err_q || m.rresp > 2'd1 || m.rlast != last;
      done_d     = last;
      state_d    = last ? IDLE : state_q;
    end
    if (tmo_hit) begin
      state_d   = IDLE;
      done_d    = 1'b1;
      err_d     = 1'b1;
      awvalid_d = 1'b0;
      arvalid_d = 1'b0;
    end
    cmd_ready_d = state_d == IDLE;
  end
  always_ff @(posedge aclk or negedge areset)
    if (!areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      rd_data_q   <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      rd_data_q   <= rd_data_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  assign cmd_ready  = cmd_ready_q;
  assign usr_wready = state_q == WDATA && m.wready;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign err        = err_q;
  assign m.awvalid  = awvalid_q;
  assign m.awaddr   = awaddr_q;
  assign m.wvalid   = state_q == WDATA && usr_wvalid;
  assign m.wdata    = state_q == WDATA ? usr_wdata : '0;
  assign m.wlast    = state_q == WDATA && last;
  assign m.bready   = state_q == WRESP;
  assign m.arvalid  = arvalid_q;
  assign m.araddr   = araddr_q;
  assign m.rready   = state_q == RDATA;
endmodule

// File: tb/tb_axi_master.sv
// tb_axi_master: directed write/read/error/reset scenarios against axi_master with BURST_LEN=4.
module tb_axi_master;
  logic        aclk = 1'b0, areset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, usr_wvalid = 1'b0;
  logic [31:0] cmd_addr = '0, usr_wdata = '0;
  logic        cmd_ready, usr_wready, rd_valid, done, err;
  logic [31:0] rd_data;
  int          n_chk = 0, n_fail = 0;
  axi_master_if bus();
  axi_master dut (
    .aclk(aclk), .areset(areset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .usr_wvalid(usr_wvalid),
    .usr_wready(usr_wready), .usr_wdata(usr_wdata), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .m(bus)
  );
  always #5 aclk = ~aclk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge aclk);
    #1;
  endtask
  task automatic cmd(input logic w, input logic [31:0] a);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    step;
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 0);
    chk("err_cleared", err, 0);
  endtask
  task automatic wr_burst(input logic [31:0] a, input logic [31:0] base, input int aw_wait,
                          input logic [1:0] resp, input logic exp_err, input logic gap, input logic tog);
    int k = 0, hold = 0;
    cmd(1'b1, a);
    chk("awvalid_up", bus.awvalid, 1);
    chk("awaddr", bus.awaddr, a);
    repeat (aw_wait - 1) begin
      step;
      chk("awvalid_hold", bus.awvalid, 1);
      chk("awaddr_hold", bus.awaddr, a);
    end
    bus.awready = 1'b1;
    step;
    bus.awready = 1'b0;
    chk("awvalid_down", bus.awvalid, 0);
    for (int c = 0; c < 40 && k < 4; c++) begin
      usr_wvalid   = !(gap && k == 1 && hold < 3);
      hold        += (gap && k == 1 && !usr_wvalid) ? 1 : 0;
      usr_wdata    = base + k;
      bus.wready   = tog ? c[0] : 1'b1;
      #1;
      chk("wvalid_pass", bus.wvalid, usr_wvalid);
      if (bus.wvalid && bus.wready) begin
        chk("wdata", bus.wdata, base + k);
        chk("wlast", bus.wlast, k == 3);
        chk("usr_wready", usr_wready, 1);
        k++;
      end
      step;
    end
    chk("beats", k, 4);
    usr_wvalid = 1'b1;
    #1;
    chk("wvalid_gated", bus.wvalid, 0);
    chk("bready", bus.bready, 1);
    chk("awaddr_wresp", bus.awaddr, a);
    usr_wvalid = 1'b0;
    bus.wready = 1'b0;
    bus.bvalid = 1'b1;
    bus.bresp  = resp;
    step;
    bus.bvalid = 1'b0;
    bus.bresp  = 2'b00;
    chk("wr_done", done, 1);
    chk("wr_err", err, exp_err);
    chk("wr_idle", cmd_ready, 1);
    step;
    chk("wr_done_pulse", done, 0);
    chk("wr_err_held", err, exp_err);
  endtask
  task automatic rd_burst(input logic [31:0] a, input int bad_beat, input int rlast_beat, input logic exp_err);
    cmd(1'b0, a);
    chk("arvalid_up", bus.arvalid, 1);
    chk("araddr", bus.araddr, a);
    bus.arready = 1'b1;
    step;
    bus.arready = 1'b0;
    chk("arvalid_down", bus.arvalid, 0);
    chk("rready", bus.rready, 1);
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = a + 32'h90 + i;
      bus.rresp  = i == bad_beat ? 2'b10 : 2'b00;
      bus.rlast  = i == rlast_beat;
      step;
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, a + 32'h90 + i);
      chk("rd_done", done, i == 3);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    chk("rd_err", err, exp_err);
    chk("rready_idle", bus.rready, 0);
    step;
    chk("rd_valid_pulse", rd_valid, 0);
    chk("rd_done_pulse", done, 0);
    chk("rd_err_held", err, exp_err);
  endtask
  initial begin
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_rd_data", rd_data, 0);
    step;
    step;
    areset = 1'b1;
    step;
    chk("cmd_ready_after_rst", cmd_ready, 1);
    bus.rvalid = 1'b1;
    bus.bvalid = 1'b1;
    step;
    chk("idle_rvalid_ignored", rd_valid, 0);
    chk("idle_bvalid_ignored", done, 0);
    bus.rvalid = 1'b0;
    bus.bvalid = 1'b0;
    wr_burst(32'h10, 32'hA0, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    rd_burst(32'h20, 9, 3, 1'b0);
    rd_burst(32'h30, 1, 3, 1'b1);
    wr_burst(32'h50, 32'hC0, 1, 2'b00, 1'b0, 1'b1, 1'b1);
    rd_burst(32'h60, 9, 1, 1'b1);
    wr_burst(32'h70, 32'hE0, 3, 2'b10, 1'b1, 1'b0, 1'b1);
    cmd(1'b1, 32'h40);
    bus.awready = 1'b1;
    step;
    bus.awready = 1'b0;
    bus.wready  = 1'b1;
    usr_wvalid  = 1'b1;
    usr_wdata   = 32'hD0;
    step;
    usr_wdata   = 32'hD1;
    step;
    #2;
    areset = 1'b0;
    #1;
    chk("mid_rst_wvalid", bus.wvalid, 0);
    chk("mid_rst_usr_wready", usr_wready, 0);
    chk("mid_rst_wdata", bus.wdata, 0);
    chk("mid_rst_awaddr", bus.awaddr, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    usr_wvalid = 1'b0;
    bus.wready = 1'b0;
    step;
    areset = 1'b1;
    step;
    chk("cmd_ready_after_mid_rst", cmd_ready, 1);
    wr_burst(32'h80, 32'hF0, 1, 2'b00, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
